// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU and queued load results onto the single register-file write port.
// Optional WB_LOAD_BYPASS_EN lets a load skip the empty queue when the port is otherwise idle.
module wb_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADR_WIDTH    = 5,
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        aluValid,
    input  logic [ADR_WIDTH-1:0]        aluAdr,
    input  logic [DATA_WIDTH-1:0]       aluData,
    output logic                        aluReady,
    input  logic                        ldValid,
    input  logic [ADR_WIDTH-1:0]        ldAdr,
    input  logic [DATA_WIDTH-1:0]       ldData,
    output logic                        ldReady,
    output logic                        writeEnable,
    output logic [ADR_WIDTH-1:0]        writeAdr,
    output logic [DATA_WIDTH-1:0]       writeData,
    output logic [$clog2(LQ_DEPTH):0]   lqCount
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADR_WIDTH-1:0]  lq_adr  [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [3:0]            starve_cnt;

    logic                  empty, full, force_ld;
    logic                  push, pop, alu_sel, bypass, sel_valid;
    logic [ADR_WIDTH-1:0]  sel_adr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(LQ_DEPTH));
    assign force_ld = (starve_cnt == 4'(STARVE_LIMIT)) && !empty;
    assign ldReady  = !full;
    assign lqCount  = count;
    assign aluReady = !force_ld;
    // A full queue refuses the push even when the head pops in the same cycle.
    assign push     = ldValid && !full && !bypass;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_sel   = 1'b0;
        pop       = 1'b0;
        bypass    = 1'b0;
        sel_valid = 1'b0;
        sel_adr   = lq_adr[rd_ptr];
        sel_data  = lq_data[rd_ptr];
        if (force_ld) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
        end else if (aluValid) begin
            alu_sel   = 1'b1;
            sel_valid = 1'b1;
            sel_adr   = aluAdr;
            sel_data  = aluData;
        end else if (!empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
`ifdef WB_LOAD_BYPASS_EN
        end else if (ldValid) begin
            bypass    = 1'b1;
            sel_valid = 1'b1;
            sel_adr   = ldAdr;
            sel_data  = ldData;
`endif
        end
    end

    // NOTE: queue storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_adr[wr_ptr]  <= ldAdr;
            lq_data[wr_ptr] <= ldData;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (alu_sel && (starve_cnt != 4'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes to x0 still consume their slot but never assert the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeEnable <= 1'b0;
            writeAdr    <= '0;
            writeData   <= '0;
        end else if (sel_valid) begin
            writeEnable <= (sel_adr != '0);
            writeAdr    <= sel_adr;
            writeData   <= sel_data;
        end else begin
            writeEnable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, ALU/load latency, x0 writes, starvation, full queue, mid-stream reset.
// Load latency expectations follow WB_LOAD_BYPASS_EN when it is defined for the build.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid, aluReady, ldValid, ldReady, writeEnable;
    logic [4:0]  aluAdr, ldAdr, writeAdr;
    logic [31:0] aluData, ldData, writeData;
    logic [2:0]  lqCount;

    int n_cmp = 0;
    int n_err = 0;

    wb_write_arbiter #(
        .DATA_WIDTH(32), .ADR_WIDTH(5), .LQ_DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluAdr(aluAdr), .aluData(aluData), .aluReady(aluReady),
        .ldValid(ldValid), .ldAdr(ldAdr), .ldData(ldData), .ldReady(ldReady),
        .writeEnable(writeEnable), .writeAdr(writeAdr), .writeData(writeData),
        .lqCount(lqCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        aluValid = v; aluAdr = a; aluData = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] a, input logic [31:0] d);
        ldValid = v; ldAdr = a; ldData = d;
    endtask

    initial begin
        rst = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        ld(1'b0, 5'd0, 32'h0);
        cyc(); cyc();

        // Reset state
        chk("rst_we",    64'(writeEnable), 64'd0);
        chk("rst_adr",   64'(writeAdr),    64'd0);
        chk("rst_data",  64'(writeData),   64'd0);
        chk("rst_count", 64'(lqCount),     64'd0);
        chk("rst_ldrdy", 64'(ldReady),     64'd1);
        rst = 1'b0;
        cyc();

        // ALU result written one cycle after handshake
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("alu_ready", 64'(aluReady), 64'd1);
        cyc();
        alu(1'b0, 5'd0, 32'h0);
        chk("alu_we",   64'(writeEnable), 64'd1);
        chk("alu_adr",  64'(writeAdr),    64'd5);
        chk("alu_data", 64'(writeData),   64'hDEADBEEF);

        // Single load on an idle bus
        ld(1'b1, 5'd7, 32'h12345678);
        #1 chk("ld_ready", 64'(ldReady), 64'd1);
        cyc();
        ld(1'b0, 5'd0, 32'h0);
`ifdef WB_LOAD_BYPASS_EN
        chk("ld_count1", 64'(lqCount),     64'd0);
        chk("ld_we",     64'(writeEnable), 64'd1);
        chk("ld_adr",    64'(writeAdr),    64'd7);
        chk("ld_data",   64'(writeData),   64'h12345678);
        cyc();
`else
        chk("ld_count1", 64'(lqCount),     64'd1);
        chk("ld_we_n1",  64'(writeEnable), 64'd0);
        cyc();
        chk("ld_we",     64'(writeEnable), 64'd1);
        chk("ld_adr",    64'(writeAdr),    64'd7);
        chk("ld_data",   64'(writeData),   64'h12345678);
`endif
        chk("ld_count0", 64'(lqCount), 64'd0);

        // ALU write to x0: handshake completes, no write
        alu(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 chk("x0_ready", 64'(aluReady), 64'd1);
        cyc();
        alu(1'b0, 5'd0, 32'h0);
        chk("x0_we",   64'(writeEnable), 64'd0);
        chk("x0_data", 64'(writeData),   64'hFFFFFFFF);
        cyc();
        chk("idle_we",   64'(writeEnable), 64'd0);
        chk("idle_hold", 64'(writeData),   64'hFFFFFFFF);

        // Starvation: one load queued behind a continuous ALU stream
        alu(1'b1, 5'd10, 32'hA0);
        ld(1'b1, 5'd9, 32'h99);
        cyc();
        ld(1'b0, 5'd0, 32'h0);
        chk("st_count", 64'(lqCount), 64'd1);
        chk("st_w0",    64'(writeAdr), 64'd10);
        for (int i = 1; i <= 3; i++) begin
            alu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            #1 chk($sformatf("st_rdy%0d", i), 64'(aluReady), 64'd1);
            cyc();
            chk($sformatf("st_w%0d", i), 64'(writeAdr), 64'(10 + i));
        end
        alu(1'b1, 5'd14, 32'hA4);
        #1 chk("st_force_rdy", 64'(aluReady), 64'd0);
        cyc();
        chk("st_force_we",   64'(writeEnable), 64'd1);
        chk("st_force_adr",  64'(writeAdr),    64'd9);
        chk("st_force_data", 64'(writeData),   64'h99);
        chk("st_force_cnt",  64'(lqCount),     64'd0);
        #1 chk("st_resume_rdy", 64'(aluReady), 64'd1);
        cyc();
        chk("st_resume_adr", 64'(writeAdr), 64'd14);

        // Fill the queue with loads 1..4 while the ALU keeps winning
        for (int i = 1; i <= 4; i++) begin
            alu(1'b1, 5'(19 + i), 32'h200 + 32'(i));
            ld(1'b1, 5'(i), 32'h100 + 32'(i));
            cyc();
            chk($sformatf("fill_cnt%0d", i), 64'(lqCount), 64'(i));
        end
        alu(1'b1, 5'd24, 32'h205);
        ld(1'b1, 5'd5, 32'h105);
        #1;
        chk("full_ldrdy",  64'(ldReady),  64'd0);
        chk("full_alurdy", 64'(aluReady), 64'd0);
        cyc();
        alu(1'b0, 5'd0, 32'h0);
        ld(1'b0, 5'd0, 32'h0);
        chk("full_cnt",   64'(lqCount),   64'd3);
        chk("order_adr1", 64'(writeAdr),  64'd1);
        chk("order_dat1", 64'(writeData), 64'h101);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk($sformatf("order_adr%0d", i), 64'(writeAdr),  64'(i));
            chk($sformatf("order_dat%0d", i), 64'(writeData), 64'h100 + 64'(i));
        end
        chk("drain_cnt", 64'(lqCount), 64'd0);
        cyc();

        // Reset asserted mid-stream with three loads queued
        for (int i = 0; i < 3; i++) begin
            alu(1'b1, 5'(25 + i), 32'h300 + 32'(i));
            ld(1'b1, 5'(17 + i), 32'h400 + 32'(i));
            cyc();
        end
        ld(1'b0, 5'd0, 32'h0);
        chk("mid_cnt3", 64'(lqCount),     64'd3);
        chk("mid_we1",  64'(writeEnable), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 64'(lqCount),     64'd0);
        chk("mid_rst_we",  64'(writeEnable), 64'd0);
        alu(1'b0, 5'd0, 32'h0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("post_rst_we%0d", i),  64'(writeEnable), 64'd0);
            chk($sformatf("post_rst_cnt%0d", i), 64'(lqCount),     64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
